// File: rtl/icache_assoc.sv
// Set-associative instruction cache with LRU replacement and word-by-word line refill.
// Hits answer the next cycle; misses fetch the whole line from memory, then respond.
`timescale 1ns/1ps

module icache_assoc #(
  parameter int ADDR_WIDTH = 32,
  parameter int SETS       = 16,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [31:0]           if_instr,
  output logic                  if_valid,
  input  logic                  flush,
  input  logic                  invalidate,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_data,
  input  logic                  mem_done,
  output logic [31:0]           miss_count
);

  localparam int OFF_W      = $clog2(LINE_WORDS);
  localparam int IDX_W      = $clog2(SETS);
  localparam int TAG_W      = ADDR_WIDTH - 2 - OFF_W - IDX_W;
  localparam int CNT_W      = (OFF_W > 0) ? OFF_W : 1;
  localparam int LINE_SHIFT = 2 + OFF_W;
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(LINE_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE_WORDS * 4 - 1);

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_RESPOND} state_t;

  state_t r_state, w_next_state;

  logic [31:0]      r_data  [SETS][WAYS][LINE_WORDS];
  logic [TAG_W-1:0] r_tag   [SETS][WAYS];
  logic [WAYS-1:0]  r_valid [SETS];
  logic [SETS-1:0]  r_lru;

  logic                  r_hit_valid;
  logic [31:0]           r_if_instr;
  logic                  r_mem_req;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_miss_count;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      r_off_l;
  logic [IDX_W-1:0]      r_idx_l;
  logic [TAG_W-1:0]      r_tag_l;
  logic                  r_victim;
  logic                  r_flushed;
  logic                  r_inv_pending;

  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_idx;
  logic [CNT_W-1:0] w_off;
  logic             w_hit, w_hit_way, w_victim;
  logic [31:0]      w_hit_word;
  logic             w_idle, w_accept, w_hit_acc, w_miss_acc;
  logic             w_fill, w_last, w_resp_done;

  assign w_tag = if_addr[ADDR_WIDTH-1 -: TAG_W];
  assign w_idx = if_addr[LINE_SHIFT +: IDX_W];

  generate
    if (OFF_W > 0) begin : g_off
      assign w_off = if_addr[2 +: OFF_W];
    end else begin : g_no_off
      assign w_off = '0;
    end
  endgenerate

  // A concurrent invalidate turns every lookup into a miss.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag) && !invalidate) begin
        w_hit     = 1'b1;
        w_hit_way = 1'(w);
      end
    end
  end

  always_comb begin
    w_victim = 1'b0;
    if (WAYS > 1 && !invalidate && r_valid[w_idx][0])
      w_victim = r_valid[w_idx][WAYS-1] ? r_lru[w_idx] : 1'b1;
  end

  assign w_hit_word  = r_data[w_idx][w_hit_way][w_off];
  assign w_idle      = (r_state == S_IDLE);
  assign w_accept    = rdy && w_idle && if_req && !flush;
  assign w_hit_acc   = w_accept && w_hit;
  assign w_miss_acc  = w_accept && !w_hit;
  assign w_fill      = rdy && (r_state == S_REFILL) && mem_done;
  assign w_last      = w_fill && (r_cnt == CNT_LAST);
  assign w_resp_done = rdy && (r_state == S_RESPOND);

  // NOTE: every branch starts from a default, so no path through this block infers a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (w_miss_acc)  w_next_state = S_REFILL;
      S_REFILL:  if (w_last)      w_next_state = S_RESPOND;
      S_RESPOND: if (w_resp_done) w_next_state = S_IDLE;
      default:                    w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so each flop samples pre-edge values whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: line data and tags carry no reset; the valid bits alone decide whether a line can hit.
  always_ff @(posedge clk) begin
    if (w_fill) r_data[r_idx_l][r_victim][r_cnt] <= mem_data;
    if (w_last) r_tag[r_idx_l][r_victim] <= r_tag_l;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_valid   <= 1'b0;
      r_if_instr    <= '0;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
      r_miss_count  <= '0;
      r_cnt         <= '0;
      r_off_l       <= '0;
      r_idx_l       <= '0;
      r_tag_l       <= '0;
      r_victim      <= 1'b0;
      r_flushed     <= 1'b0;
      r_inv_pending <= 1'b0;
      r_lru         <= '0;
      for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
    end else if (rdy) begin
      r_hit_valid <= w_hit_acc;
      if (w_hit_acc) begin
        r_if_instr   <= w_hit_word;
        r_lru[w_idx] <= ~w_hit_way;
      end
      if (w_idle && invalidate) begin
        for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
      end
      if (w_miss_acc) begin
        r_miss_count <= r_miss_count + 32'd1;
        r_mem_addr   <= if_addr & ~LINE_MASK;
        r_mem_req    <= 1'b1;
        r_cnt        <= '0;
        r_off_l      <= w_off;
        r_idx_l      <= w_idx;
        r_tag_l      <= w_tag;
        r_victim     <= w_victim;
        r_flushed    <= 1'b0;
      end
      if (!w_idle && invalidate)             r_inv_pending <= 1'b1;
      if ((r_state == S_REFILL) && flush)    r_flushed     <= 1'b1;
      // The requested word is captured as it streams past, so RESPOND needs no array read.
      if (w_fill) begin
        if (r_cnt == r_off_l) r_if_instr <= mem_data;
        if (w_last) begin
          r_mem_req                  <= 1'b0;
          r_valid[r_idx_l][r_victim] <= 1'b1;
          r_lru[r_idx_l]             <= ~r_victim;
        end else begin
          r_cnt      <= r_cnt + 1'b1;
          r_mem_addr <= r_mem_addr + ADDR_WIDTH'(4);
        end
      end
      if (w_resp_done) begin
        if (r_inv_pending || invalidate) begin
          for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
        end
        r_inv_pending <= 1'b0;
      end
    end
  end

  // A flush arriving in the RESPOND cycle itself must still hide the response.
  assign if_valid   = r_hit_valid ||
                      ((r_state == S_RESPOND) && !r_flushed && !(rdy && flush));
  assign if_instr   = r_if_instr;
  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;
  assign miss_count = r_miss_count;

endmodule

// File: tb/tb_icache_assoc.sv
// Bench for icache_assoc: directed vector table, multi-cycle corner sequences and a
// randomized phase scored against a recency-list model of each cache set.
`timescale 1ns/1ps

module tb_icache_assoc;

  localparam int AW   = 32;
  localparam int SETS = 16;
  localparam int WAYS = 2;
  localparam int LW   = 4;

  logic          clk = 1'b0;
  logic          rst, rdy, if_req, flush, invalidate, mem_done;
  logic [AW-1:0] if_addr, mem_addr;
  logic [31:0]   if_instr, mem_data, miss_count;
  logic          if_valid, mem_req;

  int n_checks = 0;
  int n_errors = 0;

  icache_assoc #(.ADDR_WIDTH(AW), .SETS(SETS), .WAYS(WAYS), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_instr(if_instr), .if_valid(if_valid),
    .flush(flush), .invalidate(invalidate),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_done(mem_done),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Backing memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Reference model: per set, the resident line bases ordered most- to least-recently used.
  typedef logic [31:0] line_q_t[$];
  line_q_t     m_set [SETS];
  int unsigned m_miss;

  function automatic int set_of(input logic [31:0] base);
    return int'((base / (4 * LW)) % SETS);
  endfunction

  function automatic bit model_has(input logic [31:0] base);
    int s = set_of(base);
    for (int i = 0; i < m_set[s].size(); i++)
      if (m_set[s][i] == base) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_use(input logic [31:0] base);
    int s = set_of(base);
    for (int i = 0; i < m_set[s].size(); i++) begin
      if (m_set[s][i] == base) begin
        m_set[s].delete(i);
        break;
      end
    end
    if (m_set[s].size() == WAYS) void'(m_set[s].pop_back());
    m_set[s].push_front(base);
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < SETS; s++) m_set[s].delete();
  endfunction

  // One fetch from the current negedge. flush_at/inv_at: word index whose mem_done cycle
  // also carries flush/invalidate (flush_at == LW flushes in the response cycle);
  // stall_at: word index preceded by 3 cycles of rdy=0 with mem_done=1 and junk data.
  task automatic fetch(input logic [31:0] addr, input int flush_at, input int stall_at,
                       input int inv_at, output bit hit);
    logic [31:0] base;
    bit          exp_hit, flushed, inv_late;
    int          lat;
    base     = addr & ~32'(4 * LW - 1);
    exp_hit  = model_has(base);
    flushed  = 1'b0;
    inv_late = 1'b0;
    if_req   = 1'b1;
    if_addr  = addr;
    @(negedge clk);
    invalidate = 1'b0;
    hit = !mem_req;
    model_use(base);
    if (exp_hit) begin
      check("hit_mem_req", 32'(mem_req), 32'd0);
      check("hit_valid", 32'(if_valid), 32'd1);
      check("hit_instr", if_instr, mem_word(addr & ~32'd3));
      check("hit_miss_count", miss_count, m_miss);
      if_req = 1'b0;
      return;
    end
    m_miss++;
    check("miss_mem_req", 32'(mem_req), 32'd1);
    check("miss_valid", 32'(if_valid), 32'd0);
    check("miss_count", miss_count, m_miss);
    for (int k = 0; k < LW; k++) begin
      if (k == stall_at) begin
        rdy = 1'b0; mem_done = 1'b1; mem_data = 32'hDEAD_BEEF;
        repeat (3) begin
          @(negedge clk);
          check("stall_addr", mem_addr, base + 32'(4 * k));
          check("stall_req", 32'(mem_req), 32'd1);
          check("stall_valid", 32'(if_valid), 32'd0);
          check("stall_miss_count", miss_count, m_miss);
        end
        rdy = 1'b1; mem_done = 1'b0; mem_data = '0;
      end
      lat = int'($urandom_range(0, 2));
      repeat (lat) @(negedge clk);
      check("refill_addr", mem_addr, base + 32'(4 * k));
      check("refill_req", 32'(mem_req), 32'd1);
      check("refill_valid", 32'(if_valid), 32'd0);
      mem_done = 1'b1;
      mem_data = mem_word(base + 32'(4 * k));
      if (k == flush_at) begin flush = 1'b1; if_req = 1'b0; flushed = 1'b1; end
      if (k == inv_at)   begin invalidate = 1'b1; inv_late = 1'b1; end
      @(negedge clk);
      mem_done = 1'b0; mem_data = '0; flush = 1'b0; invalidate = 1'b0;
    end
    check("resp_mem_req", 32'(mem_req), 32'd0);
    if_req = 1'b0;
    if (flush_at == LW) begin flush = 1'b1; flushed = 1'b1; #1; end
    check("resp_valid", 32'(if_valid), 32'(!flushed));
    if (!flushed) check("resp_instr", if_instr, mem_word(addr & ~32'd3));
    @(negedge clk);
    flush = 1'b0;
    check("post_valid", 32'(if_valid), 32'd0);
    check("post_mem_req", 32'(mem_req), 32'd0);
    if (inv_late) model_clear();
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          exp_hit;
    int unsigned exp_misses;
  } vec_t;

  vec_t vecs [9];

  initial begin
    bit h;
    vecs[0] = '{32'h0000_1004, 1'b0, 1};
    vecs[1] = '{32'h0000_1008, 1'b1, 1};
    vecs[2] = '{32'h0000_1400, 1'b0, 2};
    vecs[3] = '{32'h0000_1000, 1'b1, 2};
    vecs[4] = '{32'h0000_1800, 1'b0, 3};
    vecs[5] = '{32'h0000_1000, 1'b1, 3};
    vecs[6] = '{32'h0000_1400, 1'b0, 4};
    vecs[7] = '{32'h0000_100C, 1'b1, 4};
    vecs[8] = '{32'h0000_1800, 1'b0, 5};

    rst = 1'b1; rdy = 1'b1; if_req = 1'b0; if_addr = '0; flush = 1'b0;
    invalidate = 1'b0; mem_done = 1'b0; mem_data = '0; m_miss = 0;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_instr", if_instr, 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      fetch(vecs[i].addr, -1, -1, -1, h);
      check("vec_hit", 32'(h), 32'(vecs[i].exp_hit));
      check("vec_misses", miss_count, vecs[i].exp_misses);
    end

    fetch(32'h0000_2044, 1, -1, -1, h);
    fetch(32'h0000_2048, -1, -1, -1, h);
    check("flush_line_installed", 32'(h), 32'd1);
    fetch(32'h0000_2084, LW, -1, -1, h);
    fetch(32'h0000_2080, -1, -1, -1, h);
    check("resp_flush_line_installed", 32'(h), 32'd1);

    if_req = 1'b1; if_addr = 32'h0000_1000; flush = 1'b1;
    @(negedge clk);
    check("idle_flush_valid", 32'(if_valid), 32'd0);
    check("idle_flush_mem_req", 32'(mem_req), 32'd0);
    check("idle_flush_misses", miss_count, m_miss);
    if_req = 1'b0; flush = 1'b0;

    invalidate = 1'b1;
    model_clear();
    @(negedge clk);
    invalidate = 1'b0;
    fetch(32'h0000_1000, -1, -1, -1, h);
    check("inv_idle_miss", 32'(h), 32'd0);
    invalidate = 1'b1;
    model_clear();
    fetch(32'h0000_1000, -1, -1, -1, h);
    check("inv_with_req_miss", 32'(h), 32'd0);
    fetch(32'h0000_2404, -1, -1, 2, h);
    fetch(32'h0000_2404, -1, -1, -1, h);
    check("inv_pending_clears", 32'(h), 32'd0);

    fetch(32'h0000_3004, -1, 2, -1, h);
    fetch(32'h0000_3008, -1, -1, -1, h);
    check("stall_word_hit", 32'(h), 32'd1);
    fetch(32'h0000_300C, -1, -1, -1, h);

    @(negedge clk);
    rdy = 1'b0; if_req = 1'b1; if_addr = 32'h0000_7000;
    repeat (2) begin
      @(negedge clk);
      check("rdy_low_mem_req", 32'(mem_req), 32'd0);
      check("rdy_low_misses", miss_count, m_miss);
    end
    rdy = 1'b1; if_req = 1'b0;
    @(negedge clk);

    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      int fa, sa, ia;
      a  = 32'h0001_0000 + 32'($urandom_range(0, 2)) * 32'h100
         + 32'($urandom_range(0, 3)) * 32'h10 + 32'($urandom_range(0, LW - 1)) * 32'd4;
      fa = ($urandom_range(0, 7) == 0)  ? int'($urandom_range(0, LW))     : -1;
      sa = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, LW - 1)) : -1;
      ia = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, LW - 1)) : -1;
      if ($urandom_range(0, 29) == 0) begin
        invalidate = 1'b1;
        model_clear();
      end
      fetch(a, fa, sa, ia, h);
    end

    if_req = 1'b1; if_addr = 32'h0000_5000;
    @(negedge clk);
    check("rst_mid_req", 32'(mem_req), 32'd1);
    mem_done = 1'b1; mem_data = mem_word(32'h0000_5000);
    @(negedge clk);
    mem_done = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rst_mid_mem_req", 32'(mem_req), 32'd0);
    check("rst_mid_valid", 32'(if_valid), 32'd0);
    check("rst_mid_misses", miss_count, 32'd0);
    rst = 1'b0; if_req = 1'b0;
    model_clear();
    m_miss = 0;
    @(negedge clk);
    fetch(32'h0000_5000, -1, -1, -1, h);
    check("rst_partial_line_misses", 32'(h), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
